// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Two's-complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
    function automatic logic [WORD_W-1:0] abs_w(input logic [WORD_W-1:0] v);
        return v[WORD_W-1] ? -v : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_step.sv
// ============================================================================
// Module      : md_step
// Description : One combinational iteration: Booth radix-2 add/shift or
//               restoring subtract/shift on the shared accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_step
    import cpu_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic           op_i,
    input  logic [2*W:0]   acc_i,
    input  logic           qm1_i,
    input  logic [W-1:0]   m_i,
    output logic [2*W:0]   acc_o,
    output logic           qm1_o
);

    // Upper part is W+1 bits so Booth can subtract a -2^(W-1) multiplicand.
    logic [W:0]   w_hi;
    logic [W:0]   w_m_ext;
    logic [W:0]   w_sum;
    logic [W:0]   w_shifted;
    logic [W+1:0] w_trial;

    always_comb begin
        w_hi      = acc_i[2*W:W];
        w_m_ext   = {m_i[W-1], m_i};
        w_sum     = w_hi;
        w_shifted = acc_i[2*W-1:W-1];
        w_trial   = {1'b0, w_shifted} - {2'b00, m_i};
        acc_o     = acc_i;
        qm1_o     = qm1_i;

        if (op_i == MD_MULT) begin
            case ({acc_i[0], qm1_i})
                2'b01:   w_sum = w_hi + w_m_ext;
                2'b10:   w_sum = w_hi - w_m_ext;
                default: w_sum = w_hi;
            endcase
            acc_o = {w_sum[W], w_sum, acc_i[W-1:1]};
            qm1_o = acc_i[0];
        end else begin
            // Remainder sits in the upper part, quotient bits enter at bit 0.
            if (!w_trial[W+1]) begin
                acc_o = {w_trial[W:0], acc_i[W-2:0], 1'b1};
            end else begin
                acc_o = {w_shifted, acc_i[W-2:0], 1'b0};
            end
            qm1_o = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative signed MULT/DIV sequencer holding the result in HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);

    md_state_t           state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*WORD_W:0]   acc_q;
    logic [2*WORD_W:0]   acc_d;
    logic                qm1_q;
    logic                qm1_d;
    logic [WORD_W-1:0]   m_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                busy_q;
    logic                done_q;
    logic                div_zero_q;
    logic [WORD_W-1:0]   hi_q;
    logic [WORD_W-1:0]   lo_q;
    logic                w_step_op;
    logic [WORD_W-1:0]   w_hi_d;
    logic [WORD_W-1:0]   w_lo_d;

    assign w_step_op = (state_q == ST_DIV) ? MD_DIV : MD_MULT;

    md_step #(
        .W (WORD_W)
    ) u_step (
        .op_i  (w_step_op),
        .acc_i (acc_q),
        .qm1_i (qm1_q),
        .m_i   (m_q),
        .acc_o (acc_d),
        .qm1_o (qm1_d)
    );

    // Both ops leave {upper, lower} = {product hi, lo} or {remainder, quotient}.
    always_comb begin
        w_hi_d = acc_d[2*WORD_W-1:WORD_W];
        w_lo_d = acc_d[WORD_W-1:0];
        if (state_q == ST_DIV) begin
            if (neg_rem_q) w_hi_d = -acc_d[2*WORD_W-1:WORD_W];
            if (neg_quo_q) w_lo_d = -acc_d[WORD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (start) begin
                        cnt_q <= '0;
                        qm1_q <= 1'b0;
                        if (op == MD_MULT) begin
                            state_q <= ST_MULT;
                            busy_q  <= 1'b1;
                            acc_q   <= {{(WORD_W+1){1'b0}}, b};
                            m_q     <= a;
                        end else if (b != '0) begin
                            state_q   <= ST_DIV;
                            busy_q    <= 1'b1;
                            acc_q     <= {{(WORD_W+1){1'b0}}, abs_w(a)};
                            m_q       <= abs_w(b);
                            neg_quo_q <= a[WORD_W-1] ^ b[WORD_W-1];
                            neg_rem_q <= a[WORD_W-1];
                        end else begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                        end
                    end
                end
                ST_MULT, ST_DIV: begin
                    acc_q <= acc_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= w_hi_d;
                        lo_q    <= w_lo_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam int C_ITER = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(
        .ITER (C_ITER)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit signed arithmetic; / and % truncate toward zero.
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] mh, output logic [31:0] ml,
                                  output logic dz);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        mh = exp_hi;
        ml = exp_lo;
        if (o == 1'b0) begin
            p  = sx * sy;
            mh = p[63:32];
            ml = p[31:0];
        end else if (y == 32'd0) begin
            dz = 1'b1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            mh = r[31:0];
            ml = q[31:0];
        end
    endfunction

    // Drives start in the current cycle (cycle 0) and returns in cycle 1.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input int inj, output int dcyc, output int nbusy, output bit ovl);
        dcyc  = -1;
        nbusy = 0;
        ovl   = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy && done) ovl = 1'b1;
            if (done) begin
                dcyc = c;
                break;
            end
            if (busy) nbusy++;
            if (c == inj) begin
                start = 1'b1;
                op    = 1'($urandom);
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        checks += 5;
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
        if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", div_zero); end
        if (hi !== 32'd0)      begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
        if (lo !== 32'd0)      begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
    endtask

    task automatic test_mult_directed();
        int dc, nb;
        bit ov;
        issue(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(0, dc, nb, ov);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFEB;
        checks += 6;
        if (dc !== 33)       begin errors++; $display("FAIL mult7_done_cycle got %0d want 33", dc); end
        if (nb !== 32)       begin errors++; $display("FAIL mult7_busy_cycles got %0d want 32", nb); end
        if (ov !== 1'b0)     begin errors++; $display("FAIL mult7_busy_done_overlap got 1 want 0"); end
        if (hi !== exp_hi)   begin errors++; $display("FAIL mult7_hi got %h want %h", hi, exp_hi); end
        if (lo !== exp_lo)   begin errors++; $display("FAIL mult7_lo got %h want %h", lo, exp_lo); end
        if (div_zero !== 1'b0) begin errors++; $display("FAIL mult7_dz got %b want 0", div_zero); end
        repeat (5) @(posedge clk);
        #1;
        checks += 3;
        if (done !== 1'b0)  begin errors++; $display("FAIL mult7_done_idle got %b want 0", done); end
        if (hi !== exp_hi)  begin errors++; $display("FAIL mult7_hi_hold got %h want %h", hi, exp_hi); end
        if (lo !== exp_lo)  begin errors++; $display("FAIL mult7_lo_hold got %h want %h", lo, exp_lo); end
    endtask

    task automatic test_div_directed();
        int dc, nb;
        bit ov;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, dc, nb, ov);
        exp_hi = 32'hFFFF_FFFF;
        exp_lo = 32'hFFFF_FFFD;
        checks += 4;
        if (dc !== 33)     begin errors++; $display("FAIL divm7_done_cycle got %0d want 33", dc); end
        if (nb !== 32)     begin errors++; $display("FAIL divm7_busy_cycles got %0d want 32", nb); end
        if (hi !== exp_hi) begin errors++; $display("FAIL divm7_hi got %h want %h", hi, exp_hi); end
        if (lo !== exp_lo) begin errors++; $display("FAIL divm7_lo got %h want %h", lo, exp_lo); end
        @(posedge clk); #1;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, dc, nb, ov);
        exp_hi = 32'd0;
        exp_lo = 32'h8000_0000;
        checks += 4;
        if (dc !== 33)         begin errors++; $display("FAIL divmin_done_cycle got %0d want 33", dc); end
        if (hi !== exp_hi)     begin errors++; $display("FAIL divmin_hi got %h want %h", hi, exp_hi); end
        if (lo !== exp_lo)     begin errors++; $display("FAIL divmin_lo got %h want %h", lo, exp_lo); end
        if (div_zero !== 1'b0) begin errors++; $display("FAIL divmin_dz got %b want 0", div_zero); end
    endtask

    task automatic test_div_zero();
        @(posedge clk); #1;
        issue(1'b1, 32'd5, 32'd0);
        checks += 5;
        if (done !== 1'b1)     begin errors++; $display("FAIL dz_done got %b want 1", done); end
        if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_zero); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL dz_busy got %b want 0", busy); end
        if (hi !== exp_hi)     begin errors++; $display("FAIL dz_hi got %h want %h", hi, exp_hi); end
        if (lo !== exp_lo)     begin errors++; $display("FAIL dz_lo got %h want %h", lo, exp_lo); end
        @(posedge clk); #1;
        checks += 3;
        if (done !== 1'b0)     begin errors++; $display("FAIL dz_done_after got %b want 0", done); end
        if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_after got %b want 0", div_zero); end
        if (busy !== 1'b0)     begin errors++; $display("FAIL dz_busy_after got %b want 0", busy); end
    endtask

    task automatic test_start_ignored();
        int dc, nb, extra;
        bit ov, dz;
        logic [31:0] x, y;
        x = $urandom;
        y = $urandom;
        issue(1'b0, x, y);
        wait_done(10, dc, nb, ov);
        model(1'b0, x, y, exp_hi, exp_lo, dz);
        extra = 0;
        checks += 3;
        if (dc !== 33)     begin errors++; $display("FAIL ign_done_cycle got %0d want 33", dc); end
        if (hi !== exp_hi) begin errors++; $display("FAIL ign_hi got %h want %h", hi, exp_hi); end
        if (lo !== exp_lo) begin errors++; $display("FAIL ign_lo got %h want %h", lo, exp_lo); end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL ign_extra_activity got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int dcyc[$];
        bit ov, dz;
        logic [31:0] x1, y1, x2, y2, h1, l1, h2, l2;
        logic o2;
        x1 = $urandom; y1 = $urandom;
        x2 = $urandom; y2 = $urandom | 32'd1;
        o2 = 1'($urandom);
        model(1'b0, x1, y1, h1, l1, dz);
        exp_hi = h1; exp_lo = l1;
        model(o2, x2, y2, h2, l2, dz);
        ov = 1'b0;
        start = 1'b1; op = 1'b0; a = x1; b = y1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin op = o2; a = x2; b = y2; end
            if (dcyc.size() == 1 && c == dcyc[0] + 1) start = 1'b0;
            if (busy && done) ov = 1'b1;
            if (done) begin
                dcyc.push_back(c);
                if (dcyc.size() == 1) begin
                    checks += 2;
                    if (hi !== h1) begin errors++; $display("FAIL b2b_hi1 got %h want %h", hi, h1); end
                    if (lo !== l1) begin errors++; $display("FAIL b2b_lo1 got %h want %h", lo, l1); end
                end else if (dcyc.size() == 2) begin
                    checks += 2;
                    if (hi !== h2) begin errors++; $display("FAIL b2b_hi2 got %h want %h", hi, h2); end
                    if (lo !== l2) begin errors++; $display("FAIL b2b_lo2 got %h want %h", lo, l2); end
                end
            end
        end
        start = 1'b0;
        exp_hi = h2; exp_lo = l2;
        checks += 4;
        if (dcyc.size() !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dcyc.size()); end
        if (dcyc.size() < 1 || dcyc[0] !== 33) begin errors++; $display("FAIL b2b_done1_cycle got %0d want 33", (dcyc.size() > 0) ? dcyc[0] : -1); end
        if (dcyc.size() < 2 || dcyc[1] !== 66) begin errors++; $display("FAIL b2b_done2_cycle got %0d want 66", (dcyc.size() > 1) ? dcyc[1] : -1); end
        if (ov !== 1'b0) begin errors++; $display("FAIL b2b_busy_done_overlap got 1 want 0"); end
    endtask

    task automatic test_reset_mid_op();
        int dc, nb, ndone;
        bit ov;
        issue(1'b1, $urandom, $urandom | 32'h0000_0100);
        for (int c = 1; c < 15; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy15 got %b want 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
        if (hi !== 32'd0)  begin errors++; $display("FAIL rst_mid_hi got %h want 0", hi); end
        if (lo !== 32'd0)  begin errors++; $display("FAIL rst_mid_lo got %h want 0", lo); end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL rst_mid_activity got %0d want 0", ndone); end
        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(0, dc, nb, ov);
        exp_hi = 32'h4000_0000;
        exp_lo = 32'd0;
        checks += 3;
        if (dc !== 33)     begin errors++; $display("FAIL minsq_done_cycle got %0d want 33", dc); end
        if (hi !== exp_hi) begin errors++; $display("FAIL minsq_hi got %h want %h", hi, exp_hi); end
        if (lo !== exp_lo) begin errors++; $display("FAIL minsq_lo got %h want %h", lo, exp_lo); end
    endtask

    task automatic test_random();
        int dc, nb;
        bit ov;
        logic o, dz;
        logic [31:0] x, y, mh, ml;
        for (int n = 0; n < 24; n++) begin
            o = 1'($urandom);
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: x = 32'h8000_0000;
                1: y = 32'd0;
                2: y = 32'hFFFF_FFFF;
                3: y = 32'($urandom_range(1, 9));
                4: x = 32'($urandom_range(0, 20)) - 32'd10;
                default: ;
            endcase
            model(o, x, y, mh, ml, dz);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            issue(o, x, y);
            wait_done(0, dc, nb, ov);
            if (!dz) begin
                exp_hi = mh;
                exp_lo = ml;
            end
            checks += 6;
            if (dc !== (dz ? 1 : 33))  begin errors++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", n, dc, dz ? 1 : 33); end
            if (nb !== (dz ? 0 : 32))  begin errors++; $display("FAIL rnd%0d_busy_cycles got %0d want %0d", n, nb, dz ? 0 : 32); end
            if (ov !== 1'b0)           begin errors++; $display("FAIL rnd%0d_overlap got 1 want 0", n); end
            if (div_zero !== dz)       begin errors++; $display("FAIL rnd%0d_dz got %b want %b", n, div_zero, dz); end
            if (hi !== exp_hi)         begin errors++; $display("FAIL rnd%0d_hi op=%b a=%h b=%h got %h want %h", n, o, x, y, hi, exp_hi); end
            if (lo !== exp_lo)         begin errors++; $display("FAIL rnd%0d_lo op=%b a=%h b=%h got %h want %h", n, o, x, y, lo, exp_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide sequencer for the multicycle CPU. It takes operands from the A/B operand registers on a start pulse from the control unit and runs a fixed-length radix-2 iteration. It holds the 64-bit result in HI/LO for the mfhi/mflo write-data paths. The control unit stalls on `busy` and advances on `done`; divide-by-zero is flagged for the exception path that writes EPC.

## Interface
Parameters:
- `ITER`, 32 — iteration cycles per operation; must equal operand width.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — request a new operation; sampled on the rising edge.
- `op`  in  1  — 0 = MULT (signed), 1 = DIV (signed); sampled with `start`.
- `a`  in  32  — multiplicand / dividend (REG_A output).
- `b`  in  32  — multiplier / divisor (REG_B output).
- `busy`  out  1  — operation in progress; new `start` ignored.
- `done`  out  1  — one-cycle pulse; HI/LO (or `div_zero`) valid.
- `div_zero`  out  1  — high only together with `done` when DIV had `b == 0`.
- `hi`  out  32  — MULT: product[63:32]; DIV: remainder.
- `lo`  out  32  — MULT: product[31:0]; DIV: quotient.

## Operation
- States: IDLE, MULT, DIV, DONE.
- IDLE/DONE + `start` & `op`=0 → MULT. Latch `a`, `b`; clear the 64-bit accumulator; count = 0.
- IDLE/DONE + `start` & `op`=1 & `b`≠0 → DIV. Latch |a|, |b| and the result signs; count = 0.
- IDLE/DONE + `start` & `op`=1 & `b`=0 → DONE with `div_zero`=1. HI/LO unchanged.
- MULT: Booth radix-2 step each cycle, on multiplier bit pair {b[i], b[i-1]}, with b[-1] = 0. Add/subtract the sign-extended multiplicand, then arithmetic shift right.
- DIV: restoring step each cycle on the unsigned magnitudes.
- Both: after count reaches `ITER`-1, go to DONE and load HI/LO on that same edge.
- DIV sign fixup:
  - quotient negated when signs of `a` and `b` differ (truncates toward zero);
  - remainder takes the sign of `a`.
- Special values:
  - 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. No flag.
  - 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DONE → IDLE next cycle unless `start` is high, in which case the new op is accepted (back-to-back).
- `start` in MULT/DIV: ignored, with no queuing.
- `op`, `a`, `b` may change freely after the accepting edge.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, counter 0.
- Reset mid-operation aborts the operation. HI/LO return to 0 and no `done` is produced.
- Normal op, with `start` high in cycle 0:
  - `busy`=1 in cycles 1..`ITER` (32 cycles);
  - `done`=1 and new HI/LO visible in cycle `ITER`+1 (33);
  - `busy`=0 in that cycle.
- Divide by zero: `done`=`div_zero`=1 in cycle 1; `busy` never asserts.
- HI/LO change only on the edge entering DONE with `div_zero`=0, or on reset. Otherwise they are held indefinitely.
- `busy` and `done` are never high in the same cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - the state encoding `md_state_t` (IDLE=0, MULT=1, DIV=2, DONE=3);
  - op constants `MD_MULT`=1'b0 and `MD_DIV`=1'b1;
  - `WORD_W`=32.
- One sub-module, `md_step`, is combinational: a single Booth add/shift or restoring subtract/shift per cycle on the accumulator.
- The FSM, counter, sign fixup and HI/LO registers stay in `mult_div_unit`.

## Test plan
- MULT 7 × −3 → `done` at cycle 33, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; `busy` high cycles 1–32.
- DIV −7 / 2 → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1); DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- DIV 5 / 0 → `done` and `div_zero` in cycle 1; HI/LO keep the prior values; `busy` stays 0.
- `start` pulsed again at cycle 10 of a MULT → ignored; a single `done` at cycle 33 with the original result.
- `start` held high through DONE → second op accepted back-to-back; its `done` comes 33 cycles after the first `done`.
- `reset` asserted at cycle 15 of a DIV → next cycle IDLE; HI = LO = 0; no `done` pulse; a fresh MULT 0x80000000 × 0x80000000 then yields HI = 0x40000000, LO = 0.
